// File: rtl/car_park_pkg.sv
// Shared car-park definitions: entry/exit state encodings, default capacity, sizing helper.
// Pure declarations; no latency or flow control.
package car_park_pkg;

    localparam int CAR_PARK_CAPACITY = 4;

    typedef enum logic [2:0] {
        EN_IDLE        = 3'd0,
        EN_WAIT_TICKET = 3'd1,
        EN_GATE_OPEN   = 3'd2,
        EN_FULL        = 3'd3,
        EN_ALARM       = 3'd4
    } entry_state_t;

    typedef enum logic [2:0] {
        EX_IDLE          = 3'd0,
        EX_WAIT_TICKET   = 3'd1,
        EX_GATE_OPEN     = 3'd2,
        EX_TICKET_REJECT = 3'd3,
        EX_STOP          = 3'd4,
        EX_ALARM         = 3'd5
    } exit_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/car_park_timer.sv
// Loadable saturating up-counter with synchronous clear and terminal-count compare.
// tc is combinational on the current count; no backpressure.
module car_park_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] tc_val,
    output logic         tc
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tc = (r_count == tc_val);

endmodule

// File: rtl/car_park_exit_fsm.sv
// Exit barrier controller: ticket check, gate, tailgate stop, one exit_pulse per car.
// Outputs decode the registered state; exit_pulse lags by one cycle. CARPARK_EXIT_GATE_HOLD_EN adds gate auto-close.
module car_park_exit_fsm
    import car_park_pkg::*;
#(
    parameter int MAX_SPOTS      = CAR_PARK_CAPACITY,
    parameter int TICKET_TIMEOUT = 8,
    parameter int REJECT_HOLD    = 4,
    parameter int MAX_RETRY      = 3,
    parameter int GATE_HOLD      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       exit_front,
    input  logic       exit_back,
    input  logic       ticket_valid,
    input  logic       ticket_paid,
    input  logic [2:0] occupied,
    input  logic       attendant_clr,
    output logic       LED_RED,
    output logic       LED_GREEN,
    output logic       gate_open,
    output logic       alarm,
    output logic       exit_pulse,
    output logic [2:0] STATE
);

    localparam int TW = $clog2(max3(TICKET_TIMEOUT, REJECT_HOLD, GATE_HOLD) + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    exit_state_t   r_state;
    exit_state_t   w_next;
    logic [RW-1:0] r_retry;
    logic          r_exit_pulse;
    logic [TW-1:0] w_tc_val;
    logic          w_tc;
    logic          w_tmr_en;
    logic          w_tmr_clr;
    logic          w_lot_has_car;

    assign w_lot_has_car = (MAX_SPOTS > 0) && (occupied != 3'd0);
    assign w_tmr_clr     = (w_next != r_state);

    always_comb begin
        w_tmr_en = 1'b0;
        w_tc_val = '0;
        case (r_state)
            EX_WAIT_TICKET: begin
                w_tmr_en = 1'b1;
                w_tc_val = TW'(TICKET_TIMEOUT - 1);
            end
            EX_TICKET_REJECT: begin
                w_tmr_en = 1'b1;
                w_tc_val = TW'(REJECT_HOLD - 1);
            end
`ifdef CARPARK_EXIT_GATE_HOLD_EN
            EX_GATE_OPEN: begin
                w_tmr_en = 1'b1;
                w_tc_val = TW'(GATE_HOLD - 1);
            end
`endif
            default: ;
        endcase
    end

    car_park_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_tmr_clr),
        .en       (w_tmr_en),
        .load     (1'b0),
        .load_val ('0),
        .tc_val   (w_tc_val),
        .tc       (w_tc)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            EX_IDLE:
                if (exit_front && w_lot_has_car) w_next = EX_WAIT_TICKET;
            EX_WAIT_TICKET:
                if (!exit_front)                      w_next = EX_IDLE;
                else if (ticket_valid && ticket_paid) w_next = EX_GATE_OPEN;
                else if (ticket_valid || w_tc)        w_next = EX_TICKET_REJECT;
            EX_TICKET_REJECT:
                if (w_tc) begin
                    if (r_retry == RETRY_MAX) w_next = EX_ALARM;
                    else if (exit_front)      w_next = EX_WAIT_TICKET;
                    else                      w_next = EX_IDLE;
                end
            EX_GATE_OPEN:
                if (exit_back)  w_next = exit_front ? EX_STOP : EX_IDLE;
`ifdef CARPARK_EXIT_GATE_HOLD_EN
                else if (w_tc)  w_next = exit_front ? EX_WAIT_TICKET : EX_IDLE;
`endif
            EX_STOP:
                if (!exit_back) w_next = exit_front ? EX_WAIT_TICKET : EX_IDLE;
            EX_ALARM:
                if (attendant_clr) w_next = EX_IDLE;
            default:
                w_next = EX_IDLE;
        endcase
    end

    // Retries survive WAIT<->REJECT loops and only clear on a paid ticket or a return to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= EX_IDLE;
            r_retry      <= '0;
            r_exit_pulse <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_exit_pulse <= (r_state == EX_GATE_OPEN) && exit_back;
            if ((r_state == EX_WAIT_TICKET) && (w_next == EX_TICKET_REJECT)) begin
                if (r_retry != RETRY_MAX) r_retry <= r_retry + 1'b1;
            end else if ((w_next == EX_IDLE) || (w_next == EX_GATE_OPEN)) begin
                r_retry <= '0;
            end
        end
    end

    assign LED_GREEN  = (r_state == EX_GATE_OPEN);
    assign gate_open  = (r_state == EX_GATE_OPEN);
    assign alarm      = (r_state == EX_ALARM);
    assign LED_RED    = (r_state == EX_WAIT_TICKET) || (r_state == EX_TICKET_REJECT) ||
                        (r_state == EX_STOP) || (r_state == EX_ALARM) ||
                        ((r_state == EX_IDLE) && exit_front && (occupied == 3'd0));
    assign exit_pulse = r_exit_pulse;
    assign STATE      = r_state;

endmodule

// File: tb/tb_car_park_exit_fsm.sv
// Directed bench for the exit barrier controller: vector table plus gate-hold sequence.
module tb_car_park_exit_fsm;

    logic       clk = 1'b0;
    logic       rst, exit_front, exit_back, ticket_valid, ticket_paid, attendant_clr;
    logic [2:0] occupied;
    logic       LED_RED, LED_GREEN, gate_open, alarm, exit_pulse;
    logic [2:0] STATE;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    car_park_exit_fsm dut (
        .clk           (clk),
        .rst           (rst),
        .exit_front    (exit_front),
        .exit_back     (exit_back),
        .ticket_valid  (ticket_valid),
        .ticket_paid   (ticket_paid),
        .occupied      (occupied),
        .attendant_clr (attendant_clr),
        .LED_RED       (LED_RED),
        .LED_GREEN     (LED_GREEN),
        .gate_open     (gate_open),
        .alarm         (alarm),
        .exit_pulse    (exit_pulse),
        .STATE         (STATE)
    );

    typedef struct {
        string      name;
        logic       rst, f, b, tv, tp;
        logic [2:0] occ;
        logic       clr;
        logic [2:0] st;
        logic       red, grn, gate, alm, pls;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string name, input logic r, input logic f, input logic b,
                                input logic tv, input logic tp, input logic [2:0] occ, input logic clr,
                                input logic [2:0] st, input logic red, input logic grn,
                                input logic gate, input logic alm, input logic pls);
        vec_t v;
        v.name = name; v.rst = r; v.f = f; v.b = b; v.tv = tv; v.tp = tp; v.occ = occ; v.clr = clr;
        v.st = st; v.red = red; v.grn = grn; v.gate = gate; v.alm = alm; v.pls = pls;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic r, input logic f, input logic b, input logic tv,
                         input logic tp, input logic [2:0] occ, input logic clr);
        rst = r; exit_front = f; exit_back = b; ticket_valid = tv;
        ticket_paid = tp; occupied = occ; attendant_clr = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] st, input logic red, input logic grn,
                         input logic gate, input logic alm, input logic pls);
        logic [7:0] got, exp;
        got = {STATE, LED_RED, LED_GREEN, gate_open, alarm, exit_pulse};
        exp = {st, red, grn, gate, alm, pls};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got st=%0d red=%b grn=%b gate=%b alm=%b pls=%b, want st=%0d red=%b grn=%b gate=%b alm=%b pls=%b",
                     name, got[7:5], got[4], got[3], got[2], got[1], got[0],
                     st, red, grn, gate, alm, pls);
        end
    endtask

    initial begin
        // name, rst f b tv tp occ clr | st red grn gate alm pls
        add("reset",       1, 0, 0, 0, 0, 3'd0, 0,  3'd0, 0, 0, 0, 0, 0);
        // paid ticket, clean exit
        add("paid_arrive", 0, 1, 0, 0, 0, 3'd2, 0,  3'd1, 1, 0, 0, 0, 0);
        add("paid_wait",   0, 1, 0, 0, 0, 3'd2, 0,  3'd1, 1, 0, 0, 0, 0);
        add("paid_ticket", 0, 1, 0, 1, 1, 3'd2, 0,  3'd2, 0, 1, 1, 0, 0);
        add("paid_hold",   0, 1, 0, 0, 0, 3'd2, 0,  3'd2, 0, 1, 1, 0, 0);
        add("paid_leave",  0, 0, 1, 0, 0, 3'd2, 0,  3'd0, 0, 0, 0, 0, 1);
        add("paid_pulse1", 0, 0, 1, 0, 0, 3'd2, 0,  3'd0, 0, 0, 0, 0, 0);
        add("paid_clear",  0, 0, 0, 0, 0, 3'd2, 0,  3'd0, 0, 0, 0, 0, 0);
        // three unpaid tickets -> alarm
        add("unp_arrive",  0, 1, 0, 0, 0, 3'd2, 0,  3'd1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            add("unp_reject",  0, 1, 0, 1, 0, 3'd2, 0,  3'd3, 1, 0, 0, 0, 0);
            add("unp_hold_tv", 0, 1, 0, 1, 1, 3'd2, 0,  3'd3, 1, 0, 0, 0, 0);
            add("unp_hold",    0, 1, 0, 0, 0, 3'd2, 0,  3'd3, 1, 0, 0, 0, 0);
            add("unp_hold",    0, 1, 0, 0, 0, 3'd2, 0,  3'd3, 1, 0, 0, 0, 0);
            if (k < 2) add("unp_retry", 0, 1, 0, 0, 0, 3'd2, 0,  3'd1, 1, 0, 0, 0, 0);
        end
        add("alarm_enter", 0, 0, 0, 0, 0, 3'd2, 0,  3'd5, 1, 0, 0, 1, 0);
        add("alarm_ignor", 0, 1, 1, 1, 1, 3'd2, 0,  3'd5, 1, 0, 0, 1, 0);
        add("alarm_clr",   0, 0, 0, 0, 0, 3'd2, 1,  3'd0, 0, 0, 0, 0, 0);
        // ticket timeout, car backs off during hold
        for (int k = 0; k < 8; k++)
            add("tmo_wait",    0, 1, 0, 0, 0, 3'd2, 0,  3'd1, 1, 0, 0, 0, 0);
        add("tmo_reject",  0, 1, 0, 0, 0, 3'd2, 0,  3'd3, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++)
            add("tmo_hold",    0, 0, 0, 0, 0, 3'd2, 0,  3'd3, 1, 0, 0, 0, 0);
        add("tmo_idle",    0, 0, 0, 0, 0, 3'd2, 0,  3'd0, 0, 0, 0, 0, 0);
        // tailgater
        add("tg_arrive",   0, 1, 0, 0, 0, 3'd3, 0,  3'd1, 1, 0, 0, 0, 0);
        add("tg_paid",     0, 1, 0, 1, 1, 3'd3, 0,  3'd2, 0, 1, 1, 0, 0);
        add("tg_stop",     0, 1, 1, 0, 0, 3'd3, 0,  3'd4, 1, 0, 0, 0, 1);
        add("tg_no_repls", 0, 1, 1, 0, 0, 3'd3, 0,  3'd4, 1, 0, 0, 0, 0);
        add("tg_clear",    0, 1, 0, 0, 0, 3'd3, 0,  3'd1, 1, 0, 0, 0, 0);
        add("tg_reverse",  0, 0, 0, 0, 0, 3'd3, 0,  3'd0, 0, 0, 0, 0, 0);
        // empty lot sensor fault
        add("empty_red",   0, 1, 0, 0, 0, 3'd0, 0,  3'd0, 1, 0, 0, 0, 0);
        add("empty_stay",  0, 1, 1, 1, 1, 3'd0, 0,  3'd0, 1, 0, 0, 0, 0);
        add("empty_dark",  0, 0, 0, 0, 0, 3'd0, 0,  3'd0, 0, 0, 0, 0, 0);
        // reset while gate open
        add("rs_arrive",   0, 1, 0, 0, 0, 3'd1, 0,  3'd1, 1, 0, 0, 0, 0);
        add("rs_paid",     0, 1, 0, 1, 1, 3'd1, 0,  3'd2, 0, 1, 1, 0, 0);
        add("rs_reset",    1, 1, 1, 0, 0, 3'd1, 0,  3'd0, 0, 0, 0, 0, 0);
        add("rs_no_pulse", 0, 0, 1, 0, 0, 3'd1, 0,  3'd0, 0, 0, 0, 0, 0);
        add("rs_no_pls2",  0, 0, 0, 0, 0, 3'd1, 0,  3'd0, 0, 0, 0, 0, 0);

        drive(1, 0, 0, 0, 0, 3'd0, 0);
        tick();
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].f, vecs[i].b, vecs[i].tv, vecs[i].tp, vecs[i].occ, vecs[i].clr);
            tick();
            check(vecs[i].name, vecs[i].st, vecs[i].red, vecs[i].grn, vecs[i].gate,
                  vecs[i].alm, vecs[i].pls);
        end

        // gate held open with no car leaving
        drive(0, 1, 0, 0, 0, 3'd2, 0);
        tick();
        check("gh_arrive", 3'd1, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 1, 3'd2, 0);
        tick();
        check("gh_open", 3'd2, 0, 1, 1, 0, 0);
        drive(0, 1, 0, 0, 0, 3'd2, 0);
`ifdef CARPARK_EXIT_GATE_HOLD_EN
        for (int k = 0; k < 15; k++) begin
            tick();
            check("gh_holding", 3'd2, 0, 1, 1, 0, 0);
        end
        tick();
        check("gh_autoclose", 3'd1, 1, 0, 0, 0, 0);
        tick();
        check("gh_after", 3'd1, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 3'd2, 0);
        tick();
        check("gh_idle", 3'd0, 0, 0, 0, 0, 0);
`else
        for (int k = 0; k < 24; k++) begin
            tick();
            check("gh_holding", 3'd2, 0, 1, 1, 0, 0);
        end
        drive(0, 0, 1, 0, 0, 3'd2, 0);
        tick();
        check("gh_leave", 3'd0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 3'd2, 0);
        tick();
        check("gh_idle", 3'd0, 0, 0, 0, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/car_park_exit_fsm.md
Name: car_park_exit_fsm

Overview:
- Exit-barrier controller for the car park; the exit-side counterpart of the entry controller.
- Detects a car at the exit barrier, validates its paid ticket, opens the gate and detects tailgating.
- Issues a one-cycle `exit_pulse` when a car clears the barrier. The top level routes that pulse to the entry controller's `exit` input, so the occupancy count decrements.

Parameters:
- MAX_SPOTS, 4: capacity; only checked to confirm `occupied` is nonzero.
- TICKET_TIMEOUT, 8: cycles allowed in WAIT_TICKET before an automatic reject.
- REJECT_HOLD, 4: cycles the reject indication is held.
- MAX_RETRY, 3: rejects allowed before ALARM.
- GATE_HOLD, 16: auto-close timeout; used only with CARPARK_EXIT_GATE_HOLD_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- exit_front  in  1  car present at the inner (pre-gate) sensor
- exit_back  in  1  car present at the outer (post-gate) sensor
- ticket_valid  in  1  one-cycle strobe: ticket read
- ticket_paid  in  1  sampled with ticket_valid; 1 = paid
- occupied  in  3  current car count from the entry controller
- attendant_clr  in  1  attendant acknowledge; clears ALARM
- LED_RED  out  1  stop indication
- LED_GREEN  out  1  proceed indication
- gate_open  out  1  barrier actuator
- alarm  out  1  attendant alarm
- exit_pulse  out  1  registered one-cycle pulse per car exited
- STATE  out  3  current state encoding

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset: on any clk edge with rst=1, regardless of state (including mid-operation):
  - state←IDLE; timers, retry_cnt and exit_pulse←0.
  - All outputs 0; STATE=0.
- State encodings: IDLE=0, WAIT_TICKET=1, GATE_OPEN=2, TICKET_REJECT=3, STOP=4, ALARM=5. STATE mirrors the current state.
- Output decode is combinational on the current state:
  - GATE_OPEN: LED_GREEN=1, gate_open=1.
  - WAIT_TICKET, TICKET_REJECT, STOP, ALARM: LED_RED=1.
  - ALARM: alarm=1.
  - IDLE: LED_RED=1 only while exit_front=1 and occupied=0 (sensor fault). Otherwise dark.
- IDLE:
  - exit_front && occupied!=0 → WAIT_TICKET; timer cleared.
  - Otherwise stay.
- WAIT_TICKET (priority order):
  1. exit_front=0 (car reversed) → IDLE; retry_cnt cleared.
  2. ticket_valid && ticket_paid → GATE_OPEN; retry_cnt cleared.
  3. ticket_valid && !ticket_paid, or timer==TICKET_TIMEOUT-1 → TICKET_REJECT; retry_cnt+1.
  - Timer increments every cycle in this state.
- TICKET_REJECT:
  - Timer counts REJECT_HOLD cycles, then: retry_cnt==MAX_RETRY → ALARM; else exit_front → WAIT_TICKET; else → IDLE (retry_cnt cleared).
  - ticket_valid is ignored in this state.
- GATE_OPEN:
  - exit_front && exit_back (tailgater behind the departing car) → STOP; exit_pulse=1 next cycle.
  - !exit_front && exit_back → IDLE; exit_pulse=1 next cycle.
  - Otherwise hold.
- STOP:
  - Gate closed.
  - When exit_back=0 (first car clear): → WAIT_TICKET if exit_front, else IDLE. Timer cleared.
- ALARM:
  - Hold until attendant_clr=1 → IDLE; retry_cnt cleared.
  - Sensors and ticket inputs are ignored.
- exit_pulse:
  - Registered; exactly one cycle per transition out of GATE_OPEN caused by exit_back.
  - Never asserted twice for one car: a car sitting on exit_back in STOP does not re-pulse.
- Widths:
  - Timer is $clog2(max(TICKET_TIMEOUT, REJECT_HOLD, GATE_HOLD)+1) bits, saturating, cleared on every state change.
  - retry_cnt is $clog2(MAX_RETRY+1) bits, saturating at MAX_RETRY.
- No case default is left unhandled: unused encodings 6 and 7 go to IDLE next cycle.

Optional Feature:
- Macro: CARPARK_EXIT_GATE_HOLD_EN.
- Defined: in GATE_OPEN the timer counts. If it reaches GATE_HOLD-1 with exit_back never asserted, the state goes → WAIT_TICKET if exit_front, else IDLE. No exit_pulse is issued and retry_cnt is unchanged.
- Undefined: GATE_OPEN holds indefinitely until exit_back; the timer is idle in GATE_OPEN.

Decomposition:
- Package car_park_pkg holds:
  - the state encoding constants for this block, alongside the entry FSM encodings;
  - the default capacity constant (4).
- One natural sub-module, car_park_timer: a loadable, saturating up-counter with a clear input and a terminal-count compare. It is shared by the ticket-timeout, reject-hold and gate-hold uses.

Test Plan:
1. Paid ticket: occupied=2, exit_front=1; ticket_valid+paid on cycle 3 → GATE_OPEN, LED_GREEN=1. Then exit_front=0, exit_back=1 → IDLE and exactly one exit_pulse cycle.
2. Unpaid ×3: three unpaid ticket strobes, each followed by a 4-cycle reject hold → ALARM, alarm=1, gate_open=0. Then attendant_clr → IDLE, alarm=0.
3. Timeout: exit_front held, no ticket → TICKET_REJECT after 8 WAIT_TICKET cycles. Dropping exit_front during the hold → IDLE.
4. Tailgate: in GATE_OPEN, exit_front=1 and exit_back=1 → STOP, one exit_pulse, LED_RED=1. Then exit_back=0 → WAIT_TICKET.
5. Empty lot: occupied=0, exit_front=1 → stays IDLE, LED_RED=1, no exit_pulse.
6. Reset mid-GATE_OPEN: rst=1 for one edge → next cycle all outputs 0, STATE=0; a subsequent exit_back produces no pulse. With CARPARK_EXIT_GATE_HOLD_EN defined, GATE_OPEN with no exit_back exits after 16 cycles with no pulse.
